// File: rtl/fifo_adapter_pkg.sv
// Shared types and elaboration helpers for the width-ratio FIFO adapter.
// Latency: none (types, constants and constant functions only).
// Backpressure: not applicable.
package fifo_adapter_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,   // narrow writes packed into wide entries
        MODE_DOWN = 2'd1,   // wide writes unpacked into narrow reads
        MODE_PASS = 2'd2    // equal widths, plain FIFO
    } mode_e;

    localparam int ERR_CNT_W = 16;

    function automatic mode_e adapter_mode(input int in_w, input int out_w);
        if (in_w < out_w) begin
            return MODE_UP;
        end
        if (in_w > out_w) begin
            return MODE_DOWN;
        end
        return MODE_PASS;
    endfunction

    function automatic int adapter_ratio(input int in_w, input int out_w);
        return (in_w > out_w) ? (in_w / out_w) : (out_w / in_w);
    endfunction

    // Lane-count tag width; must hold the value RATIO itself, hence the +1.
    function automatic int adapter_lw(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

    function automatic bit adapter_ratio_ok(input int in_w, input int out_w);
        return (in_w > out_w) ? ((in_w % out_w) == 0) : ((out_w % in_w) == 0);
    endfunction

endpackage

// File: rtl/fifo_adapter_mem.sv
// Dual-pointer storage for wide entries plus a lane tag, with occupancy count.
// Latency: head entry is read combinationally; commit/pop take effect on the next edge.
// Backpressure: none here; the caller must not commit when full or pop when empty.
//
// Ports: clk/rst (sync, active-high); commit_vld/commit_dat/commit_tag push one
// entry; pop_vld retires the head; head_dat/head_tag show the head entry;
// cnt is the number of occupied entries (AW+1 bits).
module fifo_adapter_mem #(
    parameter int DW = 128,
    parameter int TW = 4,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          commit_vld,
    input  logic [DW-1:0] commit_dat,
    input  logic [TW-1:0] commit_tag,
    input  logic          pop_vld,
    output logic [DW-1:0] head_dat,
    output logic [TW-1:0] head_tag,
    output logic [AW:0]   cnt
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [TW-1:0] tag_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(commit_vld);
        rd_ptr_d = rd_ptr_q + AW'(pop_vld);
        // Commit and pop in the same cycle cancel out.
        cnt_d    = cnt_q + (AW+1)'(commit_vld) - (AW+1)'(pop_vld);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (commit_vld) begin
            mem_q[wr_ptr_q] <= commit_dat;
            tag_q[wr_ptr_q] <= commit_tag;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign head_tag = tag_q[rd_ptr_q];
    assign cnt      = cnt_q;

endmodule

// File: rtl/fifo_ratio_adapter.sv
// Width-converting synchronous FIFO: packs narrow writes (UP), unpacks wide writes (DOWN) or passes through.
// Latency: a committed entry is readable the cycle after commit; rd_dat is registered, valid the cycle after rd_ena.
// Backpressure: wr_full (with FULL_SLACK headroom) drops writes silently; reads while rd_empty are ignored.
//
// Ports: clk, rst (sync, active-high); wr_ena/wr_dat write side, wr_flush commits a
// partial pack (UP only), wr_full; rd_ena read strobe, rd_dat/rd_lanes registered
// read data and valid-lane count, rd_empty, rd_dat_cnt occupied entries.
// Optional macro FIFO_ADAPTER_ERR_CNT_EN adds saturating wr_drop_cnt / rd_under_cnt.
module fifo_ratio_adapter
    import fifo_adapter_pkg::*;
#(
    parameter int DATA_IN_WIDTH  = 16,
    parameter int DATA_OUT_WIDTH = 128,
    parameter int ADDR_WIDTH     = 4,
    parameter int FULL_SLACK     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_ena,
    input  logic [DATA_IN_WIDTH-1:0]  wr_dat,
    input  logic                      wr_flush,
    output logic                      wr_full,
    input  logic                      rd_ena,
    output logic [DATA_OUT_WIDTH-1:0] rd_dat,
    output logic [adapter_lw(adapter_ratio(DATA_IN_WIDTH, DATA_OUT_WIDTH))-1:0] rd_lanes,
    output logic                      rd_empty,
    output logic [ADDR_WIDTH:0]       rd_dat_cnt
`ifdef FIFO_ADAPTER_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]      wr_drop_cnt,
    output logic [ERR_CNT_W-1:0]      rd_under_cnt
`endif
);

    localparam mode_e MODE     = adapter_mode(DATA_IN_WIDTH, DATA_OUT_WIDTH);
    localparam int    RATIO    = adapter_ratio(DATA_IN_WIDTH, DATA_OUT_WIDTH);
    localparam int    LW       = adapter_lw(RATIO);
    localparam int    WIDE_W   = (DATA_IN_WIDTH > DATA_OUT_WIDTH) ? DATA_IN_WIDTH : DATA_OUT_WIDTH;
    localparam int    NARROW_W = (DATA_IN_WIDTH > DATA_OUT_WIDTH) ? DATA_OUT_WIDTH : DATA_IN_WIDTH;
    localparam int    DEPTH    = 2 ** ADDR_WIDTH;

    localparam logic [LW-1:0]         RATIO_TAG   = LW'(RATIO);
    localparam logic [ADDR_WIDTH:0]   FULL_THRESH = (ADDR_WIDTH+1)'(DEPTH - FULL_SLACK);

    if (!adapter_ratio_ok(DATA_IN_WIDTH, DATA_OUT_WIDTH)) begin : g_bad_ratio
        $fatal(1, "fifo_ratio_adapter: widths %0d/%0d are not an integer ratio",
               DATA_IN_WIDTH, DATA_OUT_WIDTH);
    end
    if (FULL_SLACK < 0 || FULL_SLACK > DEPTH - 1) begin : g_bad_slack
        $fatal(1, "fifo_ratio_adapter: FULL_SLACK %0d out of range 0..%0d",
               FULL_SLACK, DEPTH - 1);
    end

    logic              wr_acc;
    logic              rd_acc;
    logic              commit_vld;
    logic [WIDE_W-1:0] commit_dat;
    logic [LW-1:0]     commit_tag;
    logic              pop_vld;
    logic [WIDE_W-1:0] head_dat;
    logic [LW-1:0]     head_tag;
    logic [ADDR_WIDTH:0] cnt;

    logic [DATA_OUT_WIDTH-1:0] rd_nxt_dat;
    logic [LW-1:0]             rd_nxt_lanes;
    logic [DATA_OUT_WIDTH-1:0] rd_dat_q, rd_dat_d;
    logic [LW-1:0]             rd_lanes_q, rd_lanes_d;

    assign wr_full  = (cnt >= FULL_THRESH);
    assign rd_empty = (cnt == '0);
    assign wr_acc   = wr_ena && !wr_full;
    assign rd_acc   = rd_ena && !rd_empty;

    // ---------------- write side ----------------
    if (MODE == MODE_UP) begin : g_pack
        logic [WIDE_W-1:0] acc_q, acc_d, acc_w;
        logic [LW-1:0]     k_q, k_d, k_w;

        always_comb begin
            // acc_w/k_w include this cycle's accepted write, so a flush in the
            // same cycle as the last lane write commits that lane too.
            acc_w = acc_q;
            k_w   = k_q;
            if (wr_acc) begin
                acc_w[int'(k_q)*NARROW_W +: NARROW_W] = wr_dat;
                k_w = k_q + LW'(1);
            end
            acc_d      = acc_w;
            k_d        = k_w;
            commit_vld = 1'b0;
            commit_dat = acc_w;
            commit_tag = k_w;
            // Unwritten upper lanes are already zero: the accumulator is
            // cleared on every commit and on reset.
            if ((k_w == RATIO_TAG) || (wr_flush && !wr_full && (k_w != '0))) begin
                commit_vld = 1'b1;
                acc_d      = '0;
                k_d        = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q <= '0;
                k_q   <= '0;
            end else begin
                acc_q <= acc_d;
                k_q   <= k_d;
            end
        end
    end else begin : g_direct
        logic unused_flush;
        assign unused_flush = wr_flush;

        always_comb begin
            commit_vld = wr_acc;
            commit_dat = wr_dat;
            commit_tag = RATIO_TAG;
        end
    end

    // ---------------- read side ----------------
    if (MODE == MODE_DOWN) begin : g_unpack
        logic [LW-1:0] j_q, j_d;
        logic [LW-1:0] unused_tag;
        assign unused_tag = head_tag;

        always_comb begin
            rd_nxt_dat   = head_dat[int'(j_q)*NARROW_W +: NARROW_W];
            rd_nxt_lanes = LW'(1);
            pop_vld      = 1'b0;
            j_d          = j_q;
            if (rd_acc) begin
                if (j_q == LW'(RATIO - 1)) begin
                    pop_vld = 1'b1;
                    j_d     = '0;
                end else begin
                    j_d = j_q + LW'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                j_q <= '0;
            end else begin
                j_q <= j_d;
            end
        end
    end else begin : g_whole
        always_comb begin
            rd_nxt_dat   = head_dat;
            rd_nxt_lanes = head_tag;
            pop_vld      = rd_acc;
        end
    end

    always_comb begin
        rd_dat_d   = rd_dat_q;
        rd_lanes_d = rd_lanes_q;
        if (rd_acc) begin
            rd_dat_d   = rd_nxt_dat;
            rd_lanes_d = rd_nxt_lanes;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dat_q   <= '0;
            rd_lanes_q <= '0;
        end else begin
            rd_dat_q   <= rd_dat_d;
            rd_lanes_q <= rd_lanes_d;
        end
    end

    assign rd_dat     = rd_dat_q;
    assign rd_lanes   = rd_lanes_q;
    assign rd_dat_cnt = cnt;

    fifo_adapter_mem #(
        .DW (WIDE_W),
        .TW (LW),
        .AW (ADDR_WIDTH)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .commit_vld (commit_vld),
        .commit_dat (commit_dat),
        .commit_tag (commit_tag),
        .pop_vld    (pop_vld),
        .head_dat   (head_dat),
        .head_tag   (head_tag),
        .cnt        (cnt)
    );

`ifdef FIFO_ADAPTER_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [ERR_CNT_W-1:0] under_cnt_q, under_cnt_d;

    always_comb begin
        drop_cnt_d  = drop_cnt_q;
        under_cnt_d = under_cnt_q;
        if (wr_ena && wr_full && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + ERR_CNT_W'(1);
        end
        if (rd_ena && rd_empty && (under_cnt_q != '1)) begin
            under_cnt_d = under_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q  <= '0;
            under_cnt_q <= '0;
        end else begin
            drop_cnt_q  <= drop_cnt_d;
            under_cnt_q <= under_cnt_d;
        end
    end

    assign wr_drop_cnt  = drop_cnt_q;
    assign rd_under_cnt = under_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_ratio_adapter.sv
// Directed bench for fifo_ratio_adapter: a 16->128 packing instance and a 128->16 unpacking instance.
// Inputs are driven at the falling edge; outputs are checked at the following falling edge.
// Summary line reports total checks and errors.
module tb_fifo_ratio_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- UP instance: 16 -> 128 ----------------
    logic         u_rst = 1'b1;
    logic         u_wr_ena = 1'b0;
    logic [15:0]  u_wr_dat = '0;
    logic         u_wr_flush = 1'b0;
    logic         u_wr_full;
    logic         u_rd_ena = 1'b0;
    logic [127:0] u_rd_dat;
    logic [3:0]   u_rd_lanes;
    logic         u_rd_empty;
    logic [4:0]   u_rd_dat_cnt;
`ifdef FIFO_ADAPTER_ERR_CNT_EN
    logic [15:0]  u_drop_cnt, u_under_cnt;
`endif

    fifo_ratio_adapter #(
        .DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(128), .ADDR_WIDTH(4), .FULL_SLACK(1)
    ) u_up (
        .clk(clk), .rst(u_rst),
        .wr_ena(u_wr_ena), .wr_dat(u_wr_dat), .wr_flush(u_wr_flush), .wr_full(u_wr_full),
        .rd_ena(u_rd_ena), .rd_dat(u_rd_dat), .rd_lanes(u_rd_lanes),
        .rd_empty(u_rd_empty), .rd_dat_cnt(u_rd_dat_cnt)
`ifdef FIFO_ADAPTER_ERR_CNT_EN
        , .wr_drop_cnt(u_drop_cnt), .rd_under_cnt(u_under_cnt)
`endif
    );

    // ---------------- DOWN instance: 128 -> 16 ----------------
    logic         d_rst = 1'b1;
    logic         d_wr_ena = 1'b0;
    logic [127:0] d_wr_dat = '0;
    logic         d_wr_flush = 1'b0;
    logic         d_wr_full;
    logic         d_rd_ena = 1'b0;
    logic [15:0]  d_rd_dat;
    logic [3:0]   d_rd_lanes;
    logic         d_rd_empty;
    logic [4:0]   d_rd_dat_cnt;
`ifdef FIFO_ADAPTER_ERR_CNT_EN
    logic [15:0]  d_drop_cnt, d_under_cnt;
`endif

    fifo_ratio_adapter #(
        .DATA_IN_WIDTH(128), .DATA_OUT_WIDTH(16), .ADDR_WIDTH(4), .FULL_SLACK(1)
    ) u_down (
        .clk(clk), .rst(d_rst),
        .wr_ena(d_wr_ena), .wr_dat(d_wr_dat), .wr_flush(d_wr_flush), .wr_full(d_wr_full),
        .rd_ena(d_rd_ena), .rd_dat(d_rd_dat), .rd_lanes(d_rd_lanes),
        .rd_empty(d_rd_empty), .rd_dat_cnt(d_rd_dat_cnt)
`ifdef FIFO_ADAPTER_ERR_CNT_EN
        , .wr_drop_cnt(d_drop_cnt), .rd_under_cnt(d_under_cnt)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of UP-side inputs; returns at the next falling edge.
    task automatic up_cycle(input logic we, input logic [15:0] wd, input logic fl, input logic re);
        u_wr_ena   = we;
        u_wr_dat   = wd;
        u_wr_flush = fl;
        u_rd_ena   = re;
        @(negedge clk);
    endtask

    task automatic dn_cycle(input logic we, input logic [127:0] wd, input logic fl, input logic re);
        d_wr_ena   = we;
        d_wr_dat   = wd;
        d_wr_flush = fl;
        d_rd_ena   = re;
        @(negedge clk);
    endtask

    // Entry e of the fill test carries words e*8 .. e*8+7, lowest in lane 0.
    function automatic logic [127:0] up_entry(input int e);
        logic [127:0] v;
        v = '0;
        for (int l = 0; l < 8; l++) begin
            v[l*16 +: 16] = 16'(e * 8 + l);
        end
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] down_a, down_b, exp_w;
        bit we, re, cm, pm;
        int mc, mk, pops;

        down_a = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
        down_b = 128'h0017_0016_0015_0014_0013_0012_0011_0010;

        @(negedge clk);
        @(negedge clk);
        check("up_rst_dat",   u_rd_dat, 128'h0);
        check("up_rst_lanes", u_rd_lanes, 4'd0);
        check("up_rst_empty", u_rd_empty, 1'b1);
        check("up_rst_full",  u_wr_full, 1'b0);
        check("up_rst_cnt",   u_rd_dat_cnt, 5'd0);
        check("dn_rst_empty", d_rd_empty, 1'b1);
        check("dn_rst_lanes", d_rd_lanes, 4'd0);
        u_rst = 1'b0;
        d_rst = 1'b0;

        // ---- UP fill: 15 entries fit before slack-full, words 120..127 dropped
        for (int i = 0; i < 128; i++) begin
            up_cycle(1'b1, 16'(i), 1'b0, 1'b0);
        end
        check("fill_cnt",  u_rd_dat_cnt, 5'd15);
        check("fill_full", u_wr_full, 1'b1);
        for (int e = 0; e < 15; e++) begin
            up_cycle(1'b0, 16'h0, 1'b0, 1'b1);
            check($sformatf("fill_dat%0d", e), u_rd_dat, up_entry(e));
            check($sformatf("fill_lanes%0d", e), u_rd_lanes, 4'd8);
        end
        check("drain_empty", u_rd_empty, 1'b1);
        check("drain_full",  u_wr_full, 1'b0);
        up_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        check("under_hold_dat",   u_rd_dat, up_entry(14));
        check("under_hold_lanes", u_rd_lanes, 4'd8);
        check("under_cnt0",       u_rd_dat_cnt, 5'd0);

        // ---- UP flush
        up_cycle(1'b0, 16'h0, 1'b1, 1'b0);
        check("flush_empty_acc", u_rd_dat_cnt, 5'd0);
        up_cycle(1'b1, 16'h000A, 1'b0, 1'b0);
        up_cycle(1'b1, 16'h000B, 1'b0, 1'b0);
        up_cycle(1'b1, 16'h000C, 1'b0, 1'b0);
        check("partial_not_committed", u_rd_dat_cnt, 5'd0);
        up_cycle(1'b0, 16'h0, 1'b1, 1'b0);
        check("flush_cnt", u_rd_dat_cnt, 5'd1);
        up_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        check("flush_dat",   u_rd_dat, 128'h0000_0000_0000_0000_0000_000C_000B_000A);
        check("flush_lanes", u_rd_lanes, 4'd3);
        check("flush_empty", u_rd_empty, 1'b1);
        // flush in the same cycle as a write includes that word
        up_cycle(1'b1, 16'h0011, 1'b0, 1'b0);
        up_cycle(1'b1, 16'h0022, 1'b1, 1'b0);
        check("flush_wr_cnt", u_rd_dat_cnt, 5'd1);
        up_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        check("flush_wr_dat",   u_rd_dat, 128'h0022_0011);
        check("flush_wr_lanes", u_rd_lanes, 4'd2);

        // ---- reset mid-pack discards the partial words
        up_cycle(1'b1, 16'h0001, 1'b0, 1'b0);
        up_cycle(1'b1, 16'h0002, 1'b0, 1'b0);
        up_cycle(1'b1, 16'h0003, 1'b0, 1'b0);
        u_rst = 1'b1;
        up_cycle(1'b0, 16'h0, 1'b0, 1'b0);
        u_rst = 1'b0;
        check("midrst_cnt",   u_rd_dat_cnt, 5'd0);
        check("midrst_dat",   u_rd_dat, 128'h0);
        check("midrst_empty", u_rd_empty, 1'b1);
        exp_w = '0;
        for (int i = 0; i < 8; i++) begin
            up_cycle(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
            exp_w[i*16 +: 16] = 16'(16'h0100 + i);
        end
        check("midrst_new_cnt", u_rd_dat_cnt, 5'd1);
        up_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        check("midrst_dat_new",   u_rd_dat, exp_w);
        check("midrst_lanes_new", u_rd_lanes, 4'd8);

        // ---- streaming: writes cycles 0..31, reads cycles 15..46
        mc = 0;
        mk = 0;
        pops = 0;
        for (int c = 0; c < 48; c++) begin
            we = (c < 32);
            re = (c >= 15) && (c < 47);
            cm = 1'b0;
            if (we && !(mc >= 15)) begin
                mk++;
                if (mk == 8) begin
                    cm = 1'b1;
                    mk = 0;
                end
            end
            pm = re && (mc != 0);
            up_cycle(we, 16'h0009, 1'b0, re);
            mc = mc + int'(cm) - int'(pm);
            check($sformatf("stream_cnt%0d", c), u_rd_dat_cnt, 128'(mc));
            if (pm) begin
                pops++;
                check($sformatf("stream_dat%0d", c), u_rd_dat, {8{16'h0009}});
            end
        end
        up_cycle(1'b0, 16'h0, 1'b0, 1'b0);
        check("stream_pops", 128'(pops), 128'd4);

`ifdef FIFO_ADAPTER_ERR_CNT_EN
        // ---- error counters
        u_rst = 1'b1;
        up_cycle(1'b0, 16'h0, 1'b0, 1'b0);
        u_rst = 1'b0;
        check("err_rst_drop", u_drop_cnt, 16'd0);
        for (int i = 0; i < 120; i++) begin
            up_cycle(1'b1, 16'(i), 1'b0, 1'b0);
        end
        check("err_no_drop", u_drop_cnt, 16'd0);
        for (int i = 0; i < 5; i++) begin
            up_cycle(1'b1, 16'hFFFF, 1'b0, 1'b0);
        end
        check("err_drop", u_drop_cnt, 16'd5);
        for (int i = 0; i < 18; i++) begin
            up_cycle(1'b0, 16'h0, 1'b0, 1'b1);
        end
        up_cycle(1'b0, 16'h0, 1'b0, 1'b0);
        check("err_under", u_under_cnt, 16'd3);
`endif

        // ---- DOWN 128 -> 16
        dn_cycle(1'b0, 128'h0, 1'b1, 1'b0);
        check("dn_flush_ignored", d_rd_dat_cnt, 5'd0);
        dn_cycle(1'b1, down_a, 1'b0, 1'b0);
        check("dn_cnt1",   d_rd_dat_cnt, 5'd1);
        check("dn_nempty", d_rd_empty, 1'b0);
        dn_cycle(1'b1, down_b, 1'b0, 1'b0);
        check("dn_cnt2", d_rd_dat_cnt, 5'd2);
        dn_cycle(1'b0, 128'h0, 1'b0, 1'b0);
        for (int j = 0; j < 16; j++) begin
            dn_cycle(1'b0, 128'h0, 1'b0, 1'b1);
            check($sformatf("dn_dat%0d", j), d_rd_dat, (j < 8) ? 16'(j) : 16'(16'h0010 + j - 8));
            check($sformatf("dn_lanes%0d", j), d_rd_lanes, 4'd1);
            if (j == 7) begin
                check("dn_cnt_after8", d_rd_dat_cnt, 5'd1);
            end
            if (j >= 8) begin
                check($sformatf("dn_empty%0d", j), d_rd_empty, (j == 15) ? 1'b1 : 1'b0);
            end
        end
        dn_cycle(1'b0, 128'h0, 1'b0, 1'b1);
        check("dn_under_hold", d_rd_dat, 16'h0017);
        dn_cycle(1'b0, 128'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
